// File: rtl/tdm_demux_8.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_8
// Description : Receive-side 8-channel TDM demultiplexer. It tracks the slot
//               index from a frame sync and reassembles channel bits D0..D7
//               into a registered word with a one-cycle frame strobe.
//               Optional macro TDM_DEMUX8_PARITY_EN adds a 9th slot that
//               carries even parity over the 8 data slots.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [7:0] Y,
  output logic       frame_valid,
  output logic [3:0] S,
  output logic       sync_err,
  output logic       parity_err
);

  // The final slot of a frame: the parity slot when parity is enabled,
  // otherwise data slot 7.
`ifdef TDM_DEMUX8_PARITY_EN
  localparam logic [3:0] C_LAST_SLOT = 4'd8;
`else
  localparam logic [3:0] C_LAST_SLOT = 4'd7;
`endif

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] y_q, y_d;
  logic       fv_q, fv_d;
  logic       serr_q, serr_d;
  logic       perr_q, perr_d;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= 4'd0;
      sh_q    <= 8'h00;
      y_q     <= 8'h00;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sh_q    <= sh_d;
      y_q     <= y_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic: slot tracking, bit capture, frame completion and errors.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    sh_d    = sh_q;
    y_d     = y_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
    perr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only a synced valid bit can start the first frame.
        if (din_valid && sync) begin
          sh_d    = {7'b0, din};
          s_d     = 4'd1;
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (din_valid) begin
          if (sync && (s_q != 4'd0)) begin
            // Resync mid-frame: drop the partial frame, restart at slot 0.
            serr_d = 1'b1;
            sh_d   = {7'b0, din};
            s_d    = 4'd1;
          end else if (s_q == C_LAST_SLOT) begin
`ifdef TDM_DEMUX8_PARITY_EN
            // din is the parity bit; all 9 bits must XOR to zero.
            if ((^{din, sh_q}) == 1'b0) begin
              y_d  = sh_q;
              fv_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
`else
            // din is data slot 7; publish the frame directly.
            y_d  = {din, sh_q[6:0]};
            fv_d = 1'b1;
`endif
            // Frames may follow back-to-back without another sync.
            s_d = 4'd0;
          end else begin
            sh_d[s_q[2:0]] = din;
            s_d            = s_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Y           = y_q;
  assign frame_valid = fv_q;
  assign S           = s_q;
  assign sync_err    = serr_q;
  assign parity_err  = perr_q;

endmodule
`default_nettype wire

// File: doc/tdm_demux_8.md
# tdm_demux_8

Receive-side time-division demultiplexer for the 8-channel single-wire link driven by the team's 8:1 mux.
- Consumes one serial bit per valid cycle, tracks the slot index starting from a frame sync, and reassembles the 8 channel bits D0..D7.
- Presents each reassembled frame as a registered 8-bit word with a one-cycle frame strobe.
- Sits directly behind the link input, ahead of per-channel consumers.

## Interface
Parameters:
- none (frame length is fixed at 8 data slots; see Configuration).

Ports:
- clk  input  1  rising-edge clock; one clock for the whole block.
- rst_n  input  1  reset, asynchronous and active-low.
- din  input  1  serial link bit.
- din_valid  input  1  din carries a slot bit this cycle.
- sync  input  1  marks the current valid bit as slot 0; ignored when din_valid=0.
- Y  output  8  last complete frame; Y[k] = bit received in slot k (channel Dk).
- frame_valid  output  1  one-cycle pulse: Y has just been updated.
- S  output  4  slot index expected for the next valid bit (0..7, or 0..8 with parity).
- sync_err  output  1  one-cycle pulse: sync arrived mid-frame and the partial frame was dropped.
- parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without the macro).

## Operation
- State machine:
  - IDLE: waits for sync.
  - COLLECT: accumulating slots.
- IDLE:
  - din_valid && sync: capture din as slot 0, set S=1, go to COLLECT.
  - Any other valid bit is discarded and S stays 0.
- COLLECT, each din_valid cycle: din is written into shift register bit S, and S increments.
  - Cycles with din_valid=0 hold all state; gaps of any length are allowed.
- Last data slot (S=7, no parity):
  - copy the assembled 8 bits to Y, pulse frame_valid, set S=0, stay in COLLECT.
  - Back-to-back frames are therefore accepted with no sync required; the next valid bit is slot 0.
- Sync in COLLECT with S≠0:
  - pulse sync_err;
  - discard the partial frame (Y unchanged, no frame_valid);
  - take din as slot 0 and set S=1.
- Sync in COLLECT with S=0: normal frame start, no error.
- Y holds its value between frames. Only a completed, accepted frame changes Y.

## Timing
- Reset values:
  - Y=8'h00, frame_valid=0, S=0, sync_err=0, parity_err=0.
  - state=IDLE; shift register cleared.
- Reset mid-frame: all of the above apply immediately (asynchronous); the partial frame is lost. The first valid bit after reset release is not captured unless sync=1.
- Latency: Y, frame_valid, and the error pulses update on the same rising edge that samples the final slot bit, i.e. they are visible in the cycle after that bit is presented.
- S is registered and updates on the edge that samples each valid bit.
- Pulse outputs are high for exactly one cycle.

## Configuration
- Macro: TDM_DEMUX8_PARITY_EN.
- Defined:
  - Each frame has 9 slots; slot 8 is even parity over slots 0..7, and S counts 0..8.
  - On slot 8, if the XOR of the 8 data bits and the parity bit is 0: update Y and pulse frame_valid.
  - Otherwise: pulse parity_err, leave Y unchanged, no frame_valid.
  - In both cases S returns to 0.
- Undefined: 8-slot frames; parity_err is tied to 0; S never exceeds 7.

## Test plan
- Reset then frame: sync with slots 0..7 = 1,0,1,1,0,0,1,0 on consecutive cycles -> Y=8'h4D and frame_valid high for one cycle after slot 7; S back to 0.
- Gapped input: the same frame with din_valid low for 3 cycles between each slot -> identical Y=8'h4D. No pulse until the last slot; S holds during gaps.
- Back-to-back frames: frame 8'hFF followed immediately by 8'h0F with no second sync -> two frame_valid pulses 8 cycles apart; Y=8'hFF then 8'h0F.
- Mid-frame sync: 5 slots, then sync with a new full frame 8'hA5 -> sync_err pulses on the resync edge; Y unchanged until the 8'hA5 frame completes, and only one frame_valid pulse.
- Async reset: assert rst_n=0 at slot 4 between clock edges -> all outputs zero immediately. Valid bits without sync after release are ignored (S stays 0).
- Parity (macro on): frame 8'h4D with parity bit 0 -> frame_valid, Y=8'h4D. The same frame with parity bit 1 -> parity_err pulse, Y still 8'h4D, and no frame_valid.
